// File: rtl/reg_file_mp.sv
// Multi-read-port register file with x0 hard-wired to zero and a post-reset clear sequencer.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file_mp #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_REGISTER = 32,
  parameter int unsigned NUM_RD_PORTS = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_RD_PORTS*$clog2(NUM_REGISTER)-1:0] rd_addr_i,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rd_data_o,
  input  logic                                 we_i,
  input  logic [$clog2(NUM_REGISTER)-1:0]      wr_addr_i,
  input  logic [DATA_WIDTH-1:0]                wr_data_i,
  output logic                                 init_busy_o
);

  localparam int unsigned ADDR_W = $clog2(NUM_REGISTER);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t                  state;
  logic [ADDR_W-1:0]       cnt;
  logic [DATA_WIDTH-1:0]   mem [NUM_REGISTER];
  logic [ADDR_W-1:0]       ra;

  // Sequencer zeroes mem[1..N-1] after reset; x0 never needs storage since reads force 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= ADDR_W'(1);
    end else if (state == CLEAR) begin
      mem[cnt] <= '0;
      cnt      <= cnt + ADDR_W'(1);
      if (cnt == ADDR_W'(NUM_REGISTER - 1)) begin
        state <= RUN;
      end
    end else if (we_i && (wr_addr_i != '0)) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  assign init_busy_o = rst || (state == CLEAR);

  // Combinational read lanes; zero while busy or when addressing x0.
  always_comb begin
    rd_data_o = '0;
    ra        = '0;
    for (int p = 0; p < int'(NUM_RD_PORTS); p++) begin
      ra = rd_addr_i[p*ADDR_W +: ADDR_W];
      if (!init_busy_o && (ra != '0)) begin
        rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = mem[ra];
`ifdef REG_FILE_BYPASS_EN
        if (we_i && (wr_addr_i == ra)) begin
          rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = wr_data_i;
        end
`endif
      end
    end
  end

endmodule
